// File: rtl/accumulation_writeback.sv
// Drains the writeback bank of the accumulation buffer and streams it downstream.
// Reads are throttled so that FIFO occupancy plus the in-flight read never exceeds FIFO_DEPTH.
module accumulation_writeback #(
  parameter int DATA_WIDTH      = 64,
  parameter int BANK_ADDR_WIDTH = 7,
  parameter int BANK_DEPTH      = 128,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [BANK_ADDR_WIDTH:0]   num_words,
  output logic                       busy,
  output logic                       done,
  output logic                       ren_wb,
  output logic [BANK_ADDR_WIDTH-1:0] radr_wb,
  input  logic [DATA_WIDTH-1:0]      rdata_wb,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_last
);

  localparam int CW  = BANK_ADDR_WIDTH + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int FCW = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(BANK_DEPTH);
  localparam logic [FCW-1:0] FDEPTH_C = FCW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     issued_q, issued_d;
  logic [CW-1:0]     clamped;
  logic              inflight_q;
  logic              inflight_last_q;
  logic [DATA_WIDTH:0] fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FCW-1:0]    fifo_cnt_q;
  logic [DATA_WIDTH:0] head;
  logic              push, pop, last_issue, head_last;

  // Each FIFO entry carries its data word plus a flag marking the final word of the drain.
  assign head      = fifo_mem_q[rd_ptr_q];
  assign head_last = head[DATA_WIDTH];
  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = out_valid ? head[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid & head_last;
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q;

  assign busy    = (state_q == S_READ) || (state_q == S_FLUSH);
  assign done    = (state_q == S_DONE);
  assign ren_wb  = (state_q == S_READ) && ((fifo_cnt_q + FCW'(inflight_q)) < FDEPTH_C);
  assign radr_wb = ren_wb ? issued_q[BANK_ADDR_WIDTH-1:0] : '0;
  assign clamped = (num_words > DEPTH_C) ? DEPTH_C : num_words;
  assign last_issue = ren_wb && (issued_q == (count_q - CW'(1)));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          count_d  = clamped;
          issued_d = '0;
          state_d  = (clamped == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (ren_wb) issued_d = issued_q + CW'(1);
        if (last_issue) state_d = S_FLUSH;
      end
      // The last-flagged word can only reach the head after every read has been issued.
      S_FLUSH: begin
        if (pop && head_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      count_q         <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      issued_q        <= issued_d;
      inflight_q      <= ren_wb;
      inflight_last_q <= last_issue;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {inflight_last_q, rdata_wb};
  end

endmodule

// File: tb/tb_accumulation_writeback.sv
// Self-checking bench for accumulation_writeback: table vectors, random drains and corner sequences.
// Expected streams are words 'h100+i for i < min(num_words,128), delivered in order.
module tb_accumulation_writeback;

  localparam int DW = 64;
  localparam int AW = 7;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_words;
  logic          busy, done, ren_wb, out_valid, out_ready, out_last;
  logic [AW-1:0] radr_wb;
  logic [DW-1:0] rdata_wb, out_data;

  accumulation_writeback #(.DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .BANK_DEPTH(128), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words), .busy(busy), .done(done),
    .ren_wb(ren_wb), .radr_wb(radr_wb), .rdata_wb(rdata_wb), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read, junk when not enabled so mistimed captures show up.
  always @(posedge clk) rdata_wb <= ren_wb ? (DW'(radr_wb) + 64'h100) : 64'hDEAD_BEEF_DEAD_BEEF;

  // Ready pattern: 0 = always, 1 = one cycle in three, 2 = random.
  int ready_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor state
  logic [DW-1:0] got_q[$];
  int  ren_q[$];
  int  ren_tot, pop_tot, viol, last_cnt, last_idx, last_hs, done_cnt, done_cyc;
  int  start_cyc, first_ren, last_ren;
  logic busy_at_done, prev_valid, prev_ready, prev_last;
  logic [DW-1:0] prev_data;

  task automatic clear_mon();
    got_q.delete(); ren_q.delete();
    ren_tot = 0; pop_tot = 0; viol = 0; last_cnt = 0; last_idx = -1; last_hs = -1;
    done_cnt = 0; done_cyc = -1; start_cyc = -1; first_ren = -1; last_ren = -1;
    busy_at_done = 1'b1; prev_valid = 1'b0; prev_ready = 1'b0; prev_last = 1'b0; prev_data = '0;
  endtask

  always @(negedge clk) begin : mon
    int occ;
    occ = ren_tot - pop_tot;
    if (start && !busy && !rst) start_cyc = cyc;
    if (ren_wb) begin
      ren_q.push_back(int'(radr_wb));
      if (first_ren < 0) first_ren = cyc;
      last_ren = cyc;
      if (occ >= FD) viol++;
    end
    if (occ > FD) viol++;
    if (prev_valid && !prev_ready && (!out_valid || out_data !== prev_data || out_last !== prev_last)) viol++;
    if (out_last && !out_valid) viol++;
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      pop_tot++;
      if (out_last) begin
        last_cnt++;
        last_idx = got_q.size() - 1;
      end
      last_hs = cyc;
    end
    if (ren_wb) ren_tot++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
    prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data; prev_last = out_last;
  end

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    start = 1'b1;
    num_words = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic begin_drain(input int n, input int mode);
    ready_mode = mode;
    clear_mon();
    pulse_start(n);
  endtask

  // Waits for done and compares the observed drain against the reference stream of exp_n words.
  task automatic finish_drain(input int exp_n, input int mode, input string tag);
    int t, bad_d, bad_a;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    check({tag, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    bad_d = 0; bad_a = 0;
    for (int i = 0; i < got_q.size() && i < exp_n; i++)
      if (got_q[i] !== (64'h100 + 64'(i))) bad_d++;
    for (int i = 0; i < ren_q.size() && i < exp_n; i++)
      if (ren_q[i] != i) bad_a++;
    check({tag, "_words"}, 64'(got_q.size()), 64'(exp_n));
    check({tag, "_data_bad"}, 64'(bad_d), 64'd0);
    check({tag, "_reads"}, 64'(ren_q.size()), 64'(exp_n));
    check({tag, "_addr_bad"}, 64'(bad_a), 64'd0);
    check({tag, "_last_cnt"}, 64'(last_cnt), 64'(exp_n > 0 ? 1 : 0));
    check({tag, "_viol"}, 64'(viol), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
    if (exp_n > 0) begin
      check({tag, "_last_idx"}, 64'(last_idx), 64'(exp_n - 1));
      check({tag, "_done_lat"}, 64'(done_cyc), 64'(last_hs + 1));
    end else begin
      check({tag, "_done_lat"}, 64'(done_cyc), 64'(start_cyc + 1));
    end
    if (mode == 0 && exp_n > 0) begin
      check({tag, "_first_ren"}, 64'(first_ren), 64'(start_cyc + 1));
      check({tag, "_ren_span"}, 64'(last_ren - first_ren + 1), 64'(exp_n));
    end
    $display("drain %s: words=%0d reads=%0d done_cyc=%0d", tag, got_q.size(), ren_q.size(), done_cyc);
  endtask

  task automatic wait_words(input int k);
    int t;
    t = 0;
    while (got_q.size() < k && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("wait_words", 64'(got_q.size() >= k), 64'd1);
  endtask

  typedef struct {
    int n;
    int mode;
    int exp_words;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{16, 0, 16};
    vecs[1] = '{16, 1, 16};
    vecs[2] = '{0, 0, 0};
    vecs[3] = '{128, 0, 128};
    vecs[4] = '{200, 0, 128};
    vecs[5] = '{1, 1, 1};
    vecs[6] = '{129, 2, 128};
    vecs[7] = '{3, 2, 3};

    rst = 1'b1; start = 1'b0; num_words = '0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctl", 64'({busy, done, ren_wb, out_valid, out_last, radr_wb}), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      begin_drain(vecs[i].n, vecs[i].mode);
      finish_drain(vecs[i].exp_words, vecs[i].mode, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 5; i++) begin : rnd
      int n;
      n = $urandom_range(0, 200);
      begin_drain(n, 2);
      finish_drain((n < 128) ? n : 128, 2, $sformatf("rnd%0d_n%0d", i, n));
    end

    // Start pulsed mid-drain must be ignored.
    begin_drain(16, 0);
    wait_words(5);
    pulse_start(3);
    finish_drain(16, 0, "start_busy");

    // Reset mid-drain clears everything at the next edge.
    begin_drain(16, 0);
    wait_words(5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ctl", 64'({busy, done, ren_wb, out_valid, out_last, radr_wb}), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_nodone", 64'(done_cnt), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    begin_drain(4, 0);
    finish_drain(4, 0, "after_rst");

    // Back-to-back: second start in the cycle right after done.
    begin_drain(8, 1);
    finish_drain(8, 1, "b2b_a");
    begin_drain(6, 0);
    finish_drain(6, 0, "b2b_b");

    repeat (3) @(negedge clk);
    check("idle_after", 64'({busy, out_valid, ren_wb}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
